// File: rtl/shake_squeeze_ctrl.sv
// SHAKE256 squeeze sequencer: streams the rate portion of the Keccak state as 64-bit
// words, top slice first, and requests another permutation whenever a block runs out.
module shake_squeeze_ctrl #(
  parameter int RATE  = 1088,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] out_len_words,
  input  logic [RATE-1:0]  state_in,
  output logic             perm_start,
  input  logic             perm_done,
  output logic [63:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy,
  output logic             done
);

  localparam int RATE_W = RATE / 64;
  localparam int WIDX_W = (RATE_W > 1) ? $clog2(RATE_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_PERM,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [RATE-1:0]   r_snap;
  logic [LEN_W-1:0]  r_rem;
  logic [WIDX_W-1:0] r_widx;
  logic              r_perm_first;

  logic w_hs;
  logic w_rem_one;
  logic w_blk_end;

  assign w_hs      = (r_state == S_EMIT) && dout_ready;
  assign w_rem_one = (r_rem == LEN_W'(1));
  assign w_blk_end = (r_widx == WIDX_W'(RATE_W - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (out_len_words == '0) ? S_DONE : S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_hs) begin
          if (w_rem_one) begin
            w_next = S_DONE;
          end else if (w_blk_end) begin
            w_next = S_PERM;
          end
        end
      end
      S_PERM: begin
        if (perm_done) begin
          w_next = S_EMIT;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath updates are keyed on the current state so stray start/perm_done are inert.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_snap       <= '0;
      r_rem        <= '0;
      r_widx       <= '0;
      r_perm_first <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_perm_first <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (out_len_words != '0)) begin
            r_snap <= state_in;
            r_rem  <= out_len_words;
            r_widx <= '0;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            r_snap <= r_snap << 64;
            r_rem  <= r_rem - 1'b1;
            r_widx <= r_widx + 1'b1;
            if (!w_rem_one && w_blk_end) begin
              r_perm_first <= 1'b1;
            end
          end
        end
        S_PERM: begin
          if (perm_done) begin
            r_snap <= state_in;
            r_widx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign perm_start = (r_state == S_PERM) && r_perm_first;
  assign dout       = r_snap[RATE-1 -: 64];
  assign dout_valid = (r_state == S_EMIT);
  assign dout_last  = (r_state == S_EMIT) && w_rem_one;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_shake_squeeze_ctrl.sv
// Randomized bench for shake_squeeze_ctrl: words are predicted from the permutation
// blocks the bench hands out, indexed by word number within the request.
module tb_shake_squeeze_ctrl;

  localparam int RATE  = 1088;
  localparam int RW    = RATE / 64;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] out_len_words;
  logic [RATE-1:0]  state_in;
  logic             perm_start;
  logic             perm_done;
  logic [63:0]      dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             busy;
  logic             done;

  shake_squeeze_ctrl #(.RATE(RATE), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .out_len_words(out_len_words),
    .state_in(state_in), .perm_start(perm_start), .perm_done(perm_done),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [RATE-1:0] blocks [0:7];

  logic [63:0] obs_w[$];
  bit          obs_l[$];
  int n_perm, n_hs, stall_err, busy_err, first_vld_cyc, done_cyc, last_hs_cyc, vld_cnt;
  bit timed_out;

  task automatic rand_blocks();
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < RATE / 32; j++) blocks[b][j*32 +: 32] = $urandom;
  endtask

  // Word i of a request comes from block i/RW, slice counted down from the top.
  function automatic logic [63:0] ref_word(input int i);
    logic [RATE-1:0] b;
    b = blocks[i / RW];
    return b[RATE-1-64*(i % RW) -: 64];
  endfunction

  // Drives one request and records what the DUT did; rmode 0=ready high,
  // 1=ready pattern 1,0,0, 2=random. noise injects stray start/perm_done while emitting.
  task automatic squeeze(input int len, input int rmode, input int lat, input bit noise);
    int  perm_ctr, blk_idx;
    bit  prev_stall, r;
    logic [63:0] prev_w;
    logic prev_l;
    obs_w.delete(); obs_l.delete();
    n_perm = 0; n_hs = 0; stall_err = 0; busy_err = 0; vld_cnt = 0;
    first_vld_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
    perm_ctr = -1; blk_idx = 0; prev_stall = 0; prev_w = '0; prev_l = 1'b0;
    @(negedge clk);
    start = 1'b1; out_len_words = LEN_W'(len); state_in = blocks[0];
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4000 && done_cyc < 0; c++) begin
      start = 1'b0;
      perm_done = 1'b0;
      if (done) done_cyc = c;
      if (!busy) busy_err++;
      if (dout_valid) begin
        vld_cnt++;
        if (first_vld_cyc < 0) first_vld_cyc = c;
      end
      if (prev_stall && (!dout_valid || dout !== prev_w || dout_last !== prev_l)) stall_err++;
      if (perm_start) begin
        n_perm++;
        perm_ctr = lat;
      end
      if (perm_ctr == 0) begin
        blk_idx++;
        state_in  = blocks[blk_idx];
        perm_done = 1'b1;
        perm_ctr  = -1;
      end else if (perm_ctr > 0) begin
        perm_ctr--;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = ((c % 3) == 1);
        default: r = 1'($urandom_range(0, 1));
      endcase
      dout_ready = r;
      if (dout_valid && r) begin
        obs_w.push_back(dout);
        obs_l.push_back(dout_last);
        n_hs++;
        last_hs_cyc = c;
      end
      prev_stall = dout_valid && !r;
      prev_w = dout;
      prev_l = dout_last;
      if (noise && dout_valid) begin
        start = 1'($urandom_range(0, 1));
        out_len_words = LEN_W'($urandom);
        if (perm_ctr < 0 && $urandom_range(0, 3) == 0) begin
          perm_done = 1'b1;
          state_in  = {RATE{1'b1}};
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    perm_done = 1'b0;
    timed_out = (done_cyc < 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_len_words = '0; state_in = '0;
    perm_done = 1'b0; dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (dout !== 64'd0) begin n_err++; $display("FAIL reset_dout got %h want 0", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    n_cmp++; if (dout_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", dout_last); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (perm_start !== 1'b0) begin n_err++; $display("FAIL reset_perm_start got %b want 0", perm_start); end
    reset = 1'b0;
  endtask

  // Checks a completed request of len>0 against the block model.
  task automatic test_request(input string nm, input int len, input int rmode, input int lat, input bit noise);
    int bad_w, bad_l;
    squeeze(len, rmode, lat, noise);
    bad_w = 0; bad_l = 0;
    n_cmp++; if (timed_out) begin n_err++; $display("FAIL %s_timeout no done within budget", nm); end
    n_cmp++; if (n_hs != len) begin n_err++; $display("FAIL %s_handshakes got %0d want %0d", nm, n_hs, len); end
    for (int i = 0; i < n_hs && i < len; i++) begin
      if (obs_w[i] !== ref_word(i)) bad_w++;
      if (obs_l[i] != (i == len - 1)) bad_l++;
    end
    n_cmp++; if (bad_w != 0) begin n_err++; $display("FAIL %s_words got %0d wrong want 0 (word0 %h vs %h)", nm, bad_w, obs_w.size() > 0 ? obs_w[0] : 64'hx, ref_word(0)); end
    n_cmp++; if (bad_l != 0) begin n_err++; $display("FAIL %s_last got %0d misplaced want 0", nm, bad_l); end
    n_cmp++; if (n_perm != (len + RW - 1) / RW - 1) begin n_err++; $display("FAIL %s_perms got %0d want %0d", nm, n_perm, (len + RW - 1) / RW - 1); end
    n_cmp++; if (done_cyc - last_hs_cyc != 1) begin n_err++; $display("FAIL %s_done_lag got %0d want 1", nm, done_cyc - last_hs_cyc); end
    n_cmp++; if (first_vld_cyc != 1) begin n_err++; $display("FAIL %s_first_valid got cycle %0d want 1", nm, first_vld_cyc); end
    n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL %s_stall_hold got %0d changes want 0", nm, stall_err); end
    n_cmp++; if (busy_err != 0) begin n_err++; $display("FAIL %s_busy got %0d low cycles want 0", nm, busy_err); end
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL %s_after_done got done=%b busy=%b want 0 0", nm, done, busy); end
  endtask

  task automatic test_top_slice();
    for (int j = 0; j < RATE / 32; j++) blocks[0][j*32 +: 32] = 32'hA5C3_0000 + j;
    test_request("t1_len4", 4, 0, 24, 1'b0);
    n_cmp++;
    if (obs_w.size() == 4 && {obs_w[0], obs_w[1], obs_w[2], obs_w[3]} !== blocks[0][RATE-1 -: 256]) begin
      n_err++; $display("FAIL t1_truncation got %h want %h", {obs_w[0], obs_w[1], obs_w[2], obs_w[3]}, blocks[0][RATE-1 -: 256]);
    end
  endtask

  task automatic test_zero_len();
    squeeze(0, 0, 24, 1'b0);
    n_cmp++; if (done_cyc != 1) begin n_err++; $display("FAIL t5_done_cycle got %0d want 1", done_cyc); end
    n_cmp++; if (vld_cnt != 0) begin n_err++; $display("FAIL t5_valid got %0d valid cycles want 0", vld_cnt); end
    n_cmp++; if (n_perm != 0) begin n_err++; $display("FAIL t5_perms got %0d want 0", n_perm); end
  endtask

  task automatic test_reset_mid();
    int seen, c;
    bit bad;
    rand_blocks();
    @(negedge clk);
    start = 1'b1; out_len_words = LEN_W'(40); state_in = blocks[0]; dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0; c = 0;
    while (seen < 2 && c < 500) begin
      perm_done = 1'b0;
      if (perm_start) begin
        seen++;
        if (seen == 1) begin
          repeat (5) @(negedge clk);
          state_in = blocks[1]; perm_done = 1'b1;
        end
      end
      @(negedge clk);
      c++;
    end
    perm_done = 1'b0;
    n_cmp++; if (seen != 2) begin n_err++; $display("FAIL t6_second_perm got %0d perms want 2", seen); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout_last !== 1'b0 || done !== 1'b0 || perm_start !== 1'b0 || dout !== 64'd0) begin
      n_err++; $display("FAIL t6_reset_outputs got vld=%b busy=%b last=%b done=%b ps=%b dout=%h want all 0",
                        dout_valid, busy, dout_last, done, perm_start, dout);
    end
    @(negedge clk);
    perm_done = 1'b1; state_in = blocks[2];
    @(negedge clk);
    perm_done = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      if (busy !== 1'b0 || dout_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (bad) begin n_err++; $display("FAIL t6_stray_perm_done got activity want idle"); end
    test_request("t6_len1", 1, 0, 24, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      rand_blocks();
      test_request("rand", $urandom_range(1, 60), 2, $urandom_range(1, 30), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_top_slice();
    rand_blocks();
    test_request("t2_len17", 17, 0, 24, 1'b0);
    rand_blocks();
    test_request("t3_len18", 18, 0, 24, 1'b0);
    rand_blocks();
    test_request("t4_stall", 5, 1, 24, 1'b0);
    test_zero_len();
    rand_blocks();
    test_request("back_to_back", 35, 0, 3, 1'b0);
    test_request("back_to_back2", 34, 1, 1, 1'b0);
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule
